// File: rtl/vending_pkg.sv
// Vending machine shared definitions.
// Holds the controller state enumeration, slot count, field widths,
// the default timeout/reload constants and the slot price lookup.
package vending_pkg;

    localparam int NUM_ITEMS              = 20;
    localparam int DEFAULT_TIMEOUT_CYCLES = 5;
    localparam int DEFAULT_RELOAD_COUNT   = 10;

    localparam int CODE_W  = 5;
    localparam int STOCK_W = 4;
    localparam int COST_W  = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RELOAD,
        ST_DIGIT1,
        ST_DIGIT2,
        ST_CHECK,
        ST_WAIT_TRAN,
        ST_WAIT_OPEN,
        ST_WAIT_CLOSE
    } state_t;

    // Price in dollars for a slot code; codes outside 0-19 cost nothing.
    function automatic logic [COST_W-1:0] item_price(input logic [CODE_W-1:0] code);
        logic [COST_W-1:0] price;
        if (code <= 5'd3)       price = 3'd1;
        else if (code <= 5'd7)  price = 3'd2;
        else if (code <= 5'd11) price = 3'd3;
        else if (code <= 5'd15) price = 3'd4;
        else if (code <= 5'd17) price = 3'd5;
        else if (code <= 5'd19) price = 3'd6;
        else                    price = 3'd0;
        return price;
    endfunction

endpackage

// File: rtl/vending_inventory.sv
// Stock storage for all vending slots.
// Ports:
//   i_clk, i_rst_n : clock and asynchronous active-low reset (clears all stock)
//   i_load         : load every slot with RELOAD_COUNT this cycle
//   i_dec          : decrement the slot selected by i_dec_idx by one
//   i_rd_idx       : slot to read, o_rd_stock returns its count (0 if out of range)
module vending_inventory
    import vending_pkg::*;
#(
    parameter int RELOAD_COUNT = DEFAULT_RELOAD_COUNT
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_load,
    input  logic               i_dec,
    input  logic [CODE_W-1:0]  i_dec_idx,
    input  logic [CODE_W-1:0]  i_rd_idx,
    output logic [STOCK_W-1:0] o_rd_stock
);

    logic [STOCK_W-1:0] r_stock [NUM_ITEMS];

    // Load-all wins over decrement; the zero guard keeps a stray decrement
    // from wrapping an empty slot to full.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                r_stock[i] <= '0;
            end
        end else if (i_load) begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                r_stock[i] <= STOCK_W'(RELOAD_COUNT);
            end
        end else if (i_dec && (i_dec_idx < CODE_W'(NUM_ITEMS))) begin
            if (r_stock[i_dec_idx] != '0) begin
                r_stock[i_dec_idx] <= r_stock[i_dec_idx] - 1'b1;
            end
        end
    end

    assign o_rd_stock = (i_rd_idx < CODE_W'(NUM_ITEMS)) ? r_stock[i_rd_idx] : '0;

endmodule

// File: rtl/vending_machine.sv
// Card-operated vending machine controller.
// Ports:
//   i_clk, i_rst_n  : clock and asynchronous active-low reset
//   i_card_in       : card inserted, starts a transaction from idle
//   i_valid_tran    : payment approved
//   i_item_code     : decimal digit, sampled while i_key_press is high
//   i_key_press     : digit entry strobe
//   i_door_open     : dispense door state (1 = open)
//   i_reload        : restock all slots, honoured only in idle
//   o_vend          : item being dispensed
//   o_invalid_sell  : one-cycle pulse for bad, timed-out or sold-out selection
//   o_failed_tran   : one-cycle pulse when payment is not approved in time
//   o_cost          : price of the selected item while a sale is in progress
module vending_machine
    import vending_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int RELOAD_COUNT   = DEFAULT_RELOAD_COUNT
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_card_in,
    input  logic              i_valid_tran,
    input  logic [3:0]        i_item_code,
    input  logic              i_key_press,
    input  logic              i_door_open,
    input  logic              i_reload,
    output logic              o_vend,
    output logic              o_invalid_sell,
    output logic              o_failed_tran,
    output logic [COST_W-1:0] o_cost
);

    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [TIMER_W-1:0]  r_timer;
    logic [3:0]          r_tens;
    logic [3:0]          r_units;
    logic                r_vend;
    logic                r_invalid_sell;
    logic                r_failed_tran;
    logic [COST_W-1:0]   r_cost;

    logic [3:0]          w_tens_next;
    logic [3:0]          w_units_next;
    logic                w_vend_next;
    logic                w_invalid_next;
    logic                w_failed_next;
    logic [COST_W-1:0]   w_cost_next;
    logic                w_load;
    logic                w_dec;
    logic                w_timeout;
    logic                w_timed_state;
    logic [7:0]          w_code_full;
    logic [CODE_W-1:0]   w_code;
    logic                w_code_ok;
    logic [STOCK_W-1:0]  w_stock;

    // Full-width code so out-of-range digit pairs cannot alias onto a real slot.
    assign w_code_full = 8'(r_tens) * 8'd10 + 8'(r_units);
    assign w_code      = w_code_full[CODE_W-1:0];
    assign w_code_ok   = (r_tens <= 4'd1) && (r_units <= 4'd9) && (w_code_full <= 8'd19);

    // The timer counts cycles spent in the current wait state; the last
    // allowed cycle is the one where it reads TIMEOUT_CYCLES-1.
    assign w_timeout     = (r_timer == TIMER_W'(TIMEOUT_CYCLES - 1));
    assign w_timed_state = (r_state == ST_DIGIT1) || (r_state == ST_DIGIT2) ||
                           (r_state == ST_WAIT_TRAN) || (r_state == ST_WAIT_OPEN);

    vending_inventory #(
        .RELOAD_COUNT (RELOAD_COUNT)
    ) u_inventory (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_load),
        .i_dec      (w_dec),
        .i_dec_idx  (w_code),
        .i_rd_idx   (w_code),
        .o_rd_stock (w_stock)
    );

    // State, digits and registered outputs all update together so the
    // outputs reflect the state being entered.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= ST_IDLE;
            r_tens         <= '0;
            r_units        <= '0;
            r_vend         <= 1'b0;
            r_invalid_sell <= 1'b0;
            r_failed_tran  <= 1'b0;
            r_cost         <= '0;
        end else begin
            r_state        <= w_next_state;
            r_tens         <= w_tens_next;
            r_units        <= w_units_next;
            r_vend         <= w_vend_next;
            r_invalid_sell <= w_invalid_next;
            r_failed_tran  <= w_failed_next;
            r_cost         <= w_cost_next;
        end
    end

    // Restart the timer on every state change so each wait step gets its
    // own full allowance.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_timer <= '0;
        end else if ((w_next_state != r_state) || !w_timed_state) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    // Next-state and next-output logic. The error pulses default low so
    // they only last a single cycle.
    always_comb begin
        w_next_state   = r_state;
        w_tens_next    = r_tens;
        w_units_next   = r_units;
        w_vend_next    = r_vend;
        w_cost_next    = r_cost;
        w_invalid_next = 1'b0;
        w_failed_next  = 1'b0;
        w_load         = 1'b0;
        w_dec          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_vend_next = 1'b0;
                w_cost_next = '0;
                if (i_reload) begin
                    w_next_state = ST_RELOAD;
                end else if (i_card_in) begin
                    w_next_state = ST_DIGIT1;
                end
            end
            ST_RELOAD: begin
                w_load       = 1'b1;
                w_next_state = ST_IDLE;
            end
            ST_DIGIT1: begin
                if (i_key_press) begin
                    w_tens_next  = i_item_code;
                    w_next_state = ST_DIGIT2;
                end else if (w_timeout) begin
                    w_invalid_next = 1'b1;
                    w_next_state   = ST_IDLE;
                end
            end
            ST_DIGIT2: begin
                if (i_key_press) begin
                    w_units_next = i_item_code;
                    w_next_state = ST_CHECK;
                end else if (w_timeout) begin
                    w_invalid_next = 1'b1;
                    w_next_state   = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (w_code_ok && (w_stock != '0)) begin
                    w_cost_next  = item_price(w_code);
                    w_next_state = ST_WAIT_TRAN;
                end else begin
                    w_invalid_next = 1'b1;
                    w_cost_next    = '0;
                    w_next_state   = ST_IDLE;
                end
            end
            ST_WAIT_TRAN: begin
                if (i_valid_tran) begin
                    w_vend_next  = 1'b1;
                    w_next_state = ST_WAIT_OPEN;
                end else if (w_timeout) begin
                    w_failed_next = 1'b1;
                    w_cost_next   = '0;
                    w_next_state  = ST_IDLE;
                end
            end
            ST_WAIT_OPEN: begin
                if (i_door_open) begin
                    w_dec        = 1'b1;
                    w_next_state = ST_WAIT_CLOSE;
                end else if (w_timeout) begin
                    w_vend_next  = 1'b0;
                    w_cost_next  = '0;
                    w_next_state = ST_IDLE;
                end
            end
            ST_WAIT_CLOSE: begin
                if (!i_door_open) begin
                    w_vend_next  = 1'b0;
                    w_cost_next  = '0;
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign o_vend         = r_vend;
    assign o_invalid_sell = r_invalid_sell;
    assign o_failed_tran  = r_failed_tran;
    assign o_cost         = r_cost;

endmodule

// File: tb/tb_vending_machine.sv
`timescale 1ns/1ps
// Testbench for vending_machine: directed scenarios plus randomized
// transactions checked against a transaction-level stock/price model.
module tb_vending_machine;

    localparam int T        = 5;
    localparam int RELOAD_N = 10;
    localparam int NUM      = 20;

    logic       clk = 1'b0;
    logic       rstN;
    logic       cardIn;
    logic       validTran;
    logic [3:0] itemCode;
    logic       keyPress;
    logic       doorOpen;
    logic       reload;
    logic       vend;
    logic       invalidSell;
    logic       failedTran;
    logic [2:0] cost;

    int checkCount = 0;
    int errorCount = 0;
    int modelStock [NUM];

    always #5 clk = ~clk;

    vending_machine #(
        .TIMEOUT_CYCLES (T),
        .RELOAD_COUNT   (RELOAD_N)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rstN),
        .i_card_in      (cardIn),
        .i_valid_tran   (validTran),
        .i_item_code    (itemCode),
        .i_key_press    (keyPress),
        .i_door_open    (doorOpen),
        .i_reload       (reload),
        .o_vend         (vend),
        .o_invalid_sell (invalidSell),
        .o_failed_tran  (failedTran),
        .o_cost         (cost)
    );

    // Price bands: four codes per dollar up to 15, then two codes each.
    function automatic int priceOf(input int code);
        if (code < 16) return code / 4 + 1;
        if (code < 18) return 5;
        return 6;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkOuts(input string tag, input int expVend, input int expInv, input int expFail, input int expCost);
        checkOutput({tag, ".vend"}, 8'(vend), 8'(expVend));
        checkOutput({tag, ".invalid"}, 8'(invalidSell), 8'(expInv));
        checkOutput({tag, ".failed"}, 8'(failedTran), 8'(expFail));
        checkOutput({tag, ".cost"}, 8'(cost), 8'(expCost));
    endtask

    task automatic checkStock(input int idx);
        checkOutput($sformatf("stock[%0d]", idx), 8'(dut.u_inventory.r_stock[idx]), 8'(modelStock[idx]));
    endtask

    task automatic checkAllStock;
        for (int i = 0; i < NUM; i++) checkStock(i);
    endtask

    task automatic doReload;
        reload = 1'b1;
        tick;
        reload = 1'b0;
        checkOuts("reloadState", 0, 0, 0, 0);
        tick;
        for (int i = 0; i < NUM; i++) modelStock[i] = RELOAD_N;
        checkStock(0);
        checkStock(19);
    endtask

    // One full customer transaction. A delay of T or more means the
    // corresponding input never arrives, so that wait step times out.
    task automatic applyStimulus(input int tens, input int units, input int digitDelay,
                                 input int validDelay, input int doorDelay, input int closeHold,
                                 input bit noise);
        int  code;
        int  price;
        bit  accept;
        code   = tens * 10 + units;
        accept = (tens <= 1) && (units <= 9) && (code <= 19);
        if (accept) accept = modelStock[code] > 0;
        price  = accept ? priceOf(code) : 0;

        cardIn = 1'b1;
        tick;
        cardIn = 1'b0;
        checkOuts("card", 0, 0, 0, 0);
        for (int i = 0; i < digitDelay; i++) begin
            tick;
            checkOuts("digitWait", 0, 0, 0, 0);
        end
        keyPress = 1'b1;
        itemCode = 4'(tens);
        tick;
        itemCode = 4'(units);
        tick;
        keyPress = 1'b0;
        checkOuts("digits", 0, 0, 0, 0);
        tick;
        if (!accept) begin
            checkOuts("reject", 0, 1, 0, 0);
            tick;
            checkOuts("rejectEnd", 0, 0, 0, 0);
            return;
        end
        checkOuts("accept", 0, 0, 0, price);

        for (int i = 0; i < validDelay && i < T; i++) begin
            if (noise) begin
                cardIn = 1'($urandom_range(0, 1));
                reload = 1'($urandom_range(0, 1));
            end
            tick;
            if (i == T - 1) checkOuts("payTimeout", 0, 0, 1, 0);
            else            checkOuts("payWait", 0, 0, 0, price);
        end
        cardIn = 1'b0;
        reload = 1'b0;
        if (validDelay >= T) begin
            tick;
            checkOuts("payTimeoutEnd", 0, 0, 0, 0);
            return;
        end
        validTran = 1'b1;
        tick;
        validTran = 1'b0;
        checkOuts("paid", 1, 0, 0, price);

        for (int i = 0; i < doorDelay && i < T; i++) begin
            tick;
            if (i == T - 1) checkOuts("doorTimeout", 0, 0, 0, 0);
            else            checkOuts("doorWait", 1, 0, 0, price);
        end
        if (doorDelay >= T) begin
            tick;
            checkOuts("doorTimeoutEnd", 0, 0, 0, 0);
            checkStock(code);
            return;
        end
        doorOpen = 1'b1;
        tick;
        modelStock[code]--;
        checkOuts("doorOpen", 1, 0, 0, price);
        for (int i = 0; i < closeHold; i++) begin
            tick;
            checkOuts("doorHeld", 1, 0, 0, price);
        end
        doorOpen = 1'b0;
        tick;
        checkOuts("doorClosed", 0, 0, 0, 0);
        checkStock(code);
    endtask

    initial begin
        rstN      = 1'b0;
        cardIn    = 1'b0;
        validTran = 1'b0;
        itemCode  = 4'd0;
        keyPress  = 1'b0;
        doorOpen  = 1'b0;
        reload    = 1'b0;
        for (int i = 0; i < NUM; i++) modelStock[i] = 0;

        #2;
        checkOuts("reset", 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #3;
        rstN = 1'b1;
        tick;
        checkAllStock();

        // No reload yet: every slot is empty.
        applyStimulus(0, 1, 0, 0, 0, 0, 1'b0);

        doReload();
        applyStimulus(1, 1, 0, 0, 1, 2, 1'b0);
        applyStimulus(1, 9, 0, T, 0, 0, 1'b0);
        applyStimulus(2, 1, 0, 0, 0, 0, 1'b0);
        applyStimulus(0, 5, 1, 2, T, 0, 1'b0);
        applyStimulus(0, 7, 2, T - 1, T - 1, 0, 1'b0);

        // Digit entry abandoned after the first digit.
        cardIn = 1'b1;
        tick;
        cardIn   = 1'b0;
        keyPress = 1'b1;
        itemCode = 4'd1;
        tick;
        keyPress = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick;
            checkOuts($sformatf("digitTimeout%0d", i), 0, (i == T - 1) ? 1 : 0, 0, 0);
        end

        // Drain slot 2 completely, then it must be refused as sold out.
        for (int n = 0; n < RELOAD_N; n++) applyStimulus(0, 2, 0, 0, 0, 0, 1'b0);
        applyStimulus(0, 2, 0, 0, 0, 0, 1'b0);

        // Reset in the middle of a sale.
        cardIn = 1'b1;
        tick;
        cardIn   = 1'b0;
        keyPress = 1'b1;
        itemCode = 4'd1;
        tick;
        itemCode = 4'd6;
        tick;
        keyPress = 1'b0;
        tick;
        checkOuts("midAccept", 0, 0, 0, 5);
        validTran = 1'b1;
        tick;
        validTran = 1'b0;
        checkOuts("midPaid", 1, 0, 0, 5);
        rstN = 1'b0;
        #2;
        checkOuts("midReset", 0, 0, 0, 0);
        for (int i = 0; i < NUM; i++) modelStock[i] = 0;
        tick;
        doorOpen = 1'b1;
        tick;
        rstN = 1'b1;
        tick;
        doorOpen = 1'b0;
        tick;
        checkAllStock();
        applyStimulus(1, 6, 0, 0, 0, 0, 1'b0);

        doReload();
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) == 0) doReload();
            applyStimulus(int'($urandom_range(0, 2)), int'($urandom_range(0, 11)),
                          int'($urandom_range(0, 2)), int'($urandom_range(0, T)),
                          int'($urandom_range(0, T)), int'($urandom_range(0, 2)),
                          1'b1);
        end
        checkAllStock();

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/vending_machine.md
VENDING_MACHINE -- requirements
Module: vending_machine

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 5: cycles allowed for each wait step (digit, VALID_TRAN, DOOR_OPEN).
REQ-002 Parameter RELOAD_COUNT, default 10: stock loaded into every slot on RELOAD.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 CLK  input  1  clock, all state updates on rising edge.
REQ-005 RESET  input  1  asynchronous, active-low reset.
REQ-006 CARD_IN  input  1  card inserted, starts a transaction from IDLE.
REQ-007 VALID_TRAN  input  1  card payment approved.
REQ-008 ITEM_CODE  input  4  one decimal digit (0-9), sampled when KEY_PRESS=1.
REQ-009 KEY_PRESS  input  1  digit-entry strobe.
REQ-010 DOOR_OPEN  input  1  dispense door open (1) / closed (0).
REQ-011 RELOAD  input  1  restock request, honoured only in IDLE.
REQ-012 VEND  output  1  item being dispensed.
REQ-013 INVALID_SELL  output  1  one-cycle pulse: bad, timed-out or sold-out selection.
REQ-014 FAILED_TRAN  output  1  one-cycle pulse: payment not approved in time.
REQ-015 COST  output  3  price of selected item in dollars (1-6), 0 otherwise.

Function
REQ-016 The block SHALL hold 20 slots (codes 00-19), each a 4-bit stock counter.
REQ-017 Prices SHALL be: codes 00-03 $1, 04-07 $2, 08-11 $3, 12-15 $4, 16-17 $5, 18-19 $6.
REQ-018 States SHALL be IDLE, RELOAD, DIGIT1, DIGIT2, CHECK, WAIT_TRAN, WAIT_OPEN, WAIT_CLOSE.
REQ-019 In IDLE, RELOAD=1 SHALL take priority over CARD_IN, enter RELOAD, load all counters with RELOAD_COUNT in one cycle, then return to IDLE.
REQ-020 In IDLE, CARD_IN=1 (RELOAD=0) SHALL enter DIGIT1; all other inputs are ignored in IDLE.
REQ-021 In DIGIT1/DIGIT2, a cycle with KEY_PRESS=1 SHALL latch ITEM_CODE as tens/units digit and advance (DIGIT1->DIGIT2->CHECK).
REQ-022 Each digit state SHALL time out if no KEY_PRESS is seen within TIMEOUT_CYCLES cycles of entry: INVALID_SELL=1 for one cycle, then IDLE.
REQ-023 CHECK SHALL compute code=10*tens+units and reject it if tens>1, units>9, code>19 or stock=0: INVALID_SELL pulse, COST=0, IDLE.
REQ-024 On acceptance COST SHALL show the item price from the next cycle until return to IDLE, and the state SHALL be WAIT_TRAN.
REQ-025 In WAIT_TRAN, VALID_TRAN=1 within TIMEOUT_CYCLES cycles SHALL enter WAIT_OPEN with VEND=1; otherwise FAILED_TRAN=1 for one cycle, COST=0, IDLE.
REQ-026 In WAIT_OPEN, DOOR_OPEN=1 within TIMEOUT_CYCLES cycles SHALL decrement the slot counter by 1 and enter WAIT_CLOSE; on timeout VEND=0, IDLE, no decrement.
REQ-027 In WAIT_CLOSE, VEND SHALL stay 1 until DOOR_OPEN=0, then VEND=0, COST=0, IDLE.
REQ-028 Stock counters SHALL never underflow; decrement happens only when stock>=1 (guaranteed by CHECK).
REQ-029 CARD_IN, RELOAD and KEY_PRESS outside their states SHALL have no effect.
REQ-030 INVALID_SELL and FAILED_TRAN SHALL never be asserted together or together with VEND.

Reset
REQ-031 RESET=0 SHALL immediately force state IDLE, all stock counters 0, VEND=0, INVALID_SELL=0, FAILED_TRAN=0, COST=0, and latched digits 0.
REQ-032 Reset asserted mid-transaction SHALL abort it with no stock change after release.

Structure
REQ-033 Package vending_pkg SHALL hold the state enumeration, NUM_ITEMS=20, price lookup function/table, and the default timeout and reload constants.
REQ-034 Stock storage with load-all and decrement-one ports SHALL be a sub-module named vending_inventory; FSM and timeout counter stay in vending_machine.

Verification
REQ-035 Reset, no reload, CARD_IN, digits 0,1 -> INVALID_SELL pulse (stock 0), COST=0.
REQ-036 RELOAD, CARD_IN, digits 1,1, VALID_TRAN=1, DOOR_OPEN 1 then 0 -> COST=3, VEND=1 until door closes, slot 11 stock 10->9.
REQ-037 CARD_IN, digits 1,9, VALID_TRAN held 0 for 5 cycles -> FAILED_TRAN one-cycle pulse, COST 6 then 0, no VEND.
REQ-038 CARD_IN, digits 2,1 -> INVALID_SELL pulse (code 21 invalid).
REQ-039 CARD_IN, digit 1, then 7 idle cycles -> INVALID_SELL pulse at timeout, IDLE.
REQ-040 VALID_TRAN accepted, DOOR_OPEN held 0 for 5 cycles -> VEND falls, stock unchanged.
